mux_4to1_scan_ctrl: RTL and testbench

Upstream sequencer for the 4:1 decoder/tri-state multiplexer: it arbitrates four channel requests round-robin, drives the mux select `s[1:0]`, waits a programmable settle interval for the tri-state path to resolve, then samples the mux output `y` and delivers it with its channel index over a valid/ready handshake. It sits between the channel request sources and the mux, closing the loop on the mux's single-bit output.

---
 rtl/mux_4to1_scan_ctrl.sv | 134 +++++++++++++
 tb/tb_mux_4to1_scan_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_4to1_scan_ctrl.sv
// rtl/mux_4to1_scan_ctrl.sv - round-robin scan sequencer for a 4:1 tri-state mux
// Optional HOLD timeout with drop pulse is enabled by defining SCAN_TIMEOUT_EN.
module mux_4to1_scan_ctrl #(
  parameter int SETTLE  = 2,
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] req,
  input  logic       y,
  output logic [1:0] s,
  output logic [3:0] gnt,
  output logic       dout,
  output logic [1:0] dout_ch,
  output logic       dout_valid,
  input  logic       dout_ready,
  output logic       busy,
  output logic       drop
);

  if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
    $error("SETTLE must be in 1..15");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("TIMEOUT must be in 1..255");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t     state;
  logic [1:0] ptr;
  logic [3:0] settle_cnt;
  logic [1:0] pick;
  logic       pick_ok;

  // Search ptr+1, ptr+2, ptr+3, ptr; iterating downward lets the nearest hit win.
  always_comb begin
    pick    = ptr + 2'd1;
    pick_ok = 1'b0;
    for (int k = 4; k >= 1; k--) begin
      if (req[ptr + 2'(k)]) begin
        pick    = ptr + 2'(k);
        pick_ok = 1'b1;
      end
    end
  end

`ifdef SCAN_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
  logic [7:0] stall_cnt;
`else
  assign drop = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      ptr        <= 2'd3;
      settle_cnt <= 4'd0;
      s          <= 2'd0;
      gnt        <= 4'd0;
      dout       <= 1'b0;
      dout_ch    <= 2'd0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
`ifdef SCAN_TIMEOUT_EN
      stall_cnt  <= 8'd0;
      drop       <= 1'b0;
`endif
    end else begin
`ifdef SCAN_TIMEOUT_EN
      drop <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (en && pick_ok) begin
            s          <= pick;
            gnt        <= 4'b0001 << pick;
            settle_cnt <= 4'd0;
            state      <= ST_SETTLE;
            busy       <= 1'b1;
          end
        end
        ST_SETTLE: begin
          // s holds the serviced channel for the whole transaction.
          if (settle_cnt == SETTLE_LAST) begin
            dout       <= y;
            dout_ch    <= s;
            dout_valid <= 1'b1;
            state      <= ST_HOLD;
`ifdef SCAN_TIMEOUT_EN
            stall_cnt  <= 8'd0;
`endif
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        ST_HOLD: begin
          if (dout_ready) begin
            dout_valid <= 1'b0;
            gnt        <= 4'd0;
            ptr        <= s;
            state      <= ST_IDLE;
            busy       <= 1'b0;
          end
`ifdef SCAN_TIMEOUT_EN
          else if (stall_cnt == TIMEOUT_LAST) begin
            dout_valid <= 1'b0;
            gnt        <= 4'd0;
            ptr        <= s;
            state      <= ST_IDLE;
            busy       <= 1'b0;
            drop       <= 1'b1;
          end else begin
            stall_cnt <= stall_cnt + 8'd1;
          end
`endif
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_4to1_scan_ctrl.sv
// tb/tb_mux_4to1_scan_ctrl.sv - randomized self-checking bench for mux_4to1_scan_ctrl
module tb_mux_4to1_scan_ctrl;

  localparam int ST = 2;
  localparam int TO = 4;
`ifdef SCAN_TIMEOUT_EN
  localparam int BP_STALL = 3;
`else
  localparam int BP_STALL = 5;
`endif

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] req;
  logic       y;
  logic [1:0] s;
  logic [3:0] gnt;
  logic       dout;
  logic [1:0] dout_ch;
  logic       dout_valid;
  logic       dout_ready;
  logic       busy;
  logic       drop;

  int n_checks;
  int n_errors;
  int m_ptr;
  logic [1:0] m_s;

  mux_4to1_scan_ctrl #(.SETTLE(ST), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .y(y), .s(s), .gnt(gnt),
    .dout(dout), .dout_ch(dout_ch), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .busy(busy), .drop(drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Round-robin reference: first requester after the last serviced channel.
  function automatic int rr_pick(input int p, input logic [3:0] r);
    for (int k = 1; k <= 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  // Entered and left at a negedge with the DUT idle.
  task automatic run_txn(input logic [3:0] r, input int stall, input bit en_off, input bit ybit);
    int c;
    logic [1:0] c2;
    logic [3:0] oh;
    c  = rr_pick(m_ptr, r);
    c2 = c[1:0];
    oh = 4'b0001 << c2;
    en = 1'b1; req = r; y = 1'($urandom); dout_ready = 1'($urandom);
    @(negedge clk);
    n_checks++;
    if ({s, gnt, busy, dout_valid, drop} !== {c2, oh, 1'b1, 1'b0, 1'b0}) begin
      n_errors++;
      $display("FAIL grant: s/gnt/busy/valid/drop got %b %b %b %b %b exp %b %b 1 0 0", s, gnt, busy, dout_valid, drop, c2, oh);
    end
    for (int k = 0; k < ST; k++) begin
      y = (k == ST - 1) ? ybit : ~ybit;
      req = 4'($urandom); dout_ready = 1'($urandom);
      if (en_off) en = 1'b0;
      @(negedge clk);
      if (k < ST - 1) begin
        n_checks++;
        if (dout_valid !== 1'b0) begin
          n_errors++;
          $display("FAIL valid_early: got %b exp 0 at settle cycle %0d", dout_valid, k);
        end
      end
    end
    n_checks++;
    if ({dout_valid, dout, dout_ch, s, busy} !== {1'b1, ybit, c2, c2, 1'b1}) begin
      n_errors++;
      $display("FAIL sample: valid/dout/ch/s/busy got %b %b %b %b %b exp 1 %b %b %b 1", dout_valid, dout, dout_ch, s, busy, ybit, c2, c2);
    end
    for (int j = 0; j < stall; j++) begin
      dout_ready = 1'b0; y = 1'($urandom); req = 4'($urandom);
      @(negedge clk);
      n_checks++;
      if ({dout_valid, dout, dout_ch, s, gnt, drop} !== {1'b1, ybit, c2, c2, oh, 1'b0}) begin
        n_errors++;
        $display("FAIL hold_stable: got %b %b %b %b %b %b exp 1 %b %b %b %b 0 (stall %0d)", dout_valid, dout, dout_ch, s, gnt, drop, ybit, c2, c2, oh, j);
      end
    end
    dout_ready = 1'b1; req = 4'd0;
    @(negedge clk);
    n_checks++;
    if ({dout_valid, gnt, busy, s, drop} !== {1'b0, 4'd0, 1'b0, c2, 1'b0}) begin
      n_errors++;
      $display("FAIL release: valid/gnt/busy/s/drop got %b %b %b %b %b exp 0 0000 0 %b 0", dout_valid, gnt, busy, s, drop, c2);
    end
    m_ptr = c; m_s = c2;
    dout_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; req = 4'd0; y = 1'b0; dout_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({s, gnt, dout, dout_ch, dout_valid, busy, drop} !== 12'd0) begin
      n_errors++;
      $display("FAIL reset_values: got %b %b %b %b %b %b %b exp all 0", s, gnt, dout, dout_ch, dout_valid, busy, drop);
    end
    rst_n = 1'b1;
    @(negedge clk);
    en = 1'b1; req = 4'b0100;
    @(negedge clk);
    n_checks++;
    if ({s, busy} !== {2'd2, 1'b1}) begin
      n_errors++;
      $display("FAIL reset_pre_grant: s/busy got %b %b exp 10 1", s, busy);
    end
    rst_n = 1'b0; req = 4'b0001;
    #1;
    n_checks++;
    if ({s, gnt, dout, dout_ch, dout_valid, busy, drop} !== 12'd0) begin
      n_errors++;
      $display("FAIL async_reset: got %b %b %b %b %b %b %b exp all 0", s, gnt, dout, dout_ch, dout_valid, busy, drop);
    end
    @(negedge clk);
    rst_n = 1'b1; m_ptr = 3; m_s = 2'd0;
    run_txn(4'b0001, 0, 1'b0, 1'($urandom));
  endtask

  task automatic test_latency();
    run_txn(4'b0100, 0, 1'b0, 1'b1);
  endtask

  task automatic test_round_robin();
    repeat (5) run_txn(4'b1111, 0, 1'b0, 1'($urandom));
  endtask

  task automatic test_backpressure();
    run_txn(4'b0110, BP_STALL, 1'b0, 1'b1);
    run_txn(4'b1001, BP_STALL, 1'b0, 1'b0);
  endtask

  task automatic test_enable();
    en = 1'b0; req = 4'b1010;
    repeat (4) begin
      @(negedge clk);
      n_checks++;
      if ({gnt, busy, s, dout_valid} !== {4'd0, 1'b0, m_s, 1'b0}) begin
        n_errors++;
        $display("FAIL en_gate: gnt/busy/s/valid got %b %b %b %b exp 0000 0 %b 0", gnt, busy, s, dout_valid, m_s);
      end
    end
    run_txn(4'b1010, 1, 1'b1, 1'($urandom));
  endtask

  task automatic test_back_to_back();
    repeat (3) run_txn(4'b1000, 0, 1'b0, 1'($urandom));
  endtask

  task automatic test_random();
    repeat (30) run_txn(4'($urandom_range(1, 15)), $urandom_range(0, 3), 1'b0, 1'($urandom));
  endtask

  task automatic test_timeout();
`ifdef SCAN_TIMEOUT_EN
    int c;
    c = rr_pick(m_ptr, 4'b1111);
    en = 1'b1; req = 4'b1111; dout_ready = 1'b0; y = 1'b1;
    repeat (1 + ST) @(negedge clk);
    for (int j = 1; j <= TO; j++) begin
      @(negedge clk);
      n_checks++;
      if (j < TO) begin
        if ({drop, dout_valid} !== 2'b01) begin
          n_errors++;
          $display("FAIL timeout_early: drop/valid got %b %b exp 0 1 at stall %0d", drop, dout_valid, j);
        end
      end else if ({drop, dout_valid, gnt, busy} !== {1'b1, 1'b0, 4'd0, 1'b0}) begin
        n_errors++;
        $display("FAIL timeout_drop: drop/valid/gnt/busy got %b %b %b %b exp 1 0 0000 0", drop, dout_valid, gnt, busy);
      end
    end
    m_ptr = c; m_s = c[1:0];
    run_txn(4'b1111, 0, 1'b0, 1'($urandom));
    run_txn(4'b0101, TO - 1, 1'b0, 1'($urandom));
`else
    run_txn(4'b0001, 100, 1'b0, 1'b1);
`endif
  endtask

  initial begin
    n_checks = 0; n_errors = 0; m_ptr = 3; m_s = 2'd0;
    test_reset();
    test_latency();
    test_round_robin();
    test_backpressure();
    test_enable();
    test_back_to_back();
    test_random();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
